// File: rtl/sr_latch_driver_if.sv
// Handshake, latch-drive and feedback bundle for sr_latch_driver.
// master = requester plus latch cell; slave = the driver itself.
interface sr_latch_driver_if #(
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic             req_set;
  logic             ready;
  logic             s;
  logic             r;
  logic             q_fb;
  logic             qb_fb;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output req_valid,
    output req_set,
    output q_fb,
    output qb_fb,
    input  ready,
    input  s,
    input  r,
    input  done,
    input  err,
    input  err_cnt
  );

  modport slave (
    input  req_valid,
    input  req_set,
    input  q_fb,
    input  qb_fb,
    output ready,
    output s,
    output r,
    output done,
    output err,
    output err_cnt
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Pulses s or r of a NOR SR latch, settles, then checks Q/QB feedback.
// Optional SR_FB_SYNC_EN: 2-flop feedback synchronizers, settle +2 cycles.
module sr_latch_driver #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 8
) (
  input logic            clk,
  input logic            rst,
  sr_latch_driver_if.slave bus
);

`ifdef SR_FB_SYNC_EN
  localparam int SETTLE_N = GAP_W + 2;
`else
  localparam int SETTLE_N = GAP_W;
`endif
  localparam int MAX_N = (PULSE_W > SETTLE_N) ? PULSE_W : SETTLE_N;
  localparam int CW    = $clog2(MAX_N + 1);

  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_N - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    SETTLE,
    CHECK
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cmd_q, cmd_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic q_use;
  logic qb_use;
  logic pass;

`ifdef SR_FB_SYNC_EN
  logic [1:0] q_sync_q, q_sync_d;
  logic [1:0] qb_sync_q, qb_sync_d;

  always_comb begin
    q_sync_d  = {q_sync_q[0], bus.q_fb};
    qb_sync_d = {qb_sync_q[0], bus.qb_fb};
  end

  // Reset to the latch's "cleared" pattern so a fresh check is consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_sync_q  <= 2'b00;
      qb_sync_q <= 2'b11;
    end else begin
      q_sync_q  <= q_sync_d;
      qb_sync_q <= qb_sync_d;
    end
  end

  assign q_use  = q_sync_q[1];
  assign qb_use = qb_sync_q[1];
`else
  assign q_use  = bus.q_fb;
  assign qb_use = bus.qb_fb;
`endif

  assign pass = (q_use == cmd_q) && (qb_use == ~cmd_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
    ready_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = PULSE;
          cmd_d   = bus.req_set;
          cnt_d   = PULSE_LD;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          // Result is registered so it shows during the CHECK cycle.
          state_d = CHECK;
          cnt_d   = '0;
          done_d  = 1'b1;
          err_d   = ~pass;
          if (!pass && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Drives follow the next state, so s and r are exclusive by construction.
    s_d     = (state_d == PULSE) &&  cmd_d;
    r_d     = (state_d == PULSE) && !cmd_d;
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      s_q       <= s_d;
      r_q       <= r_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.s       = s_q;
  assign bus.r       = r_q;
  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed table-driven bench for sr_latch_driver with a NOR latch model.
// Expected latency follows SR_FB_SYNC_EN when it is defined.
module tb_sr_latch_driver;

  localparam int PW    = 2;
  localparam int GW    = 1;
  localparam int CNT_W = 8;
`ifdef SR_FB_SYNC_EN
  localparam int LAT = PW + GW + 3;
`else
  localparam int LAT = PW + GW + 1;
`endif

  logic clk;
  logic rst;

  sr_latch_driver_if #(.CNT_W(CNT_W)) bus ();

  sr_latch_driver #(
    .PULSE_W(PW),
    .GAP_W  (GW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  logic lq       = 1'b0;
  logic force_en = 1'b0;
  logic force_q  = 1'b0;
  logic force_qb = 1'b0;

  // Latch cell: responds mid-cycle to the registered drives.
  always @(negedge clk) begin
    if (bus.s && !bus.r) lq <= 1'b1;
    else if (bus.r && !bus.s) lq <= 1'b0;
  end

  assign bus.q_fb  = force_en ? force_q  : lq;
  assign bus.qb_fb = force_en ? force_qb : ~lq;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.s && bus.r) begin
        failures++;
        $display("FAIL s_r_exclusive act=11 exp=not_both t=%0t", $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge; that cycle is the acceptance cycle 0.
  task automatic run_op(input logic set, input logic fen, input logic fq,
                        input logic fqb, input logic experr,
                        input string tag);
    logic [4:0] expv;
    logic [4:0] actv;
    force_en      = fen;
    force_q       = fq;
    force_qb      = fqb;
    bus.req_valid = 1'b1;
    bus.req_set   = set;
    chk({tag, "_ready0"}, 32'(bus.ready), 32'd1);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      expv = {set && (k <= PW), !set && (k <= PW), k == LAT,
              (k == LAT) && experr, k == LAT + 1};
      actv = {bus.s, bus.r, bus.done, bus.err, bus.ready};
      chk($sformatf("%s_c%0d_srdeR", tag, k), 32'(actv), 32'(expv));
    end
    force_en = 1'b0;
    if (experr && exp_cnt < 255) exp_cnt++;
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'(exp_cnt));
  endtask

  typedef struct {
    logic  set;
    logic  fen;
    logic  fq;
    logic  fqb;
    logic  experr;
    string tag;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "set"};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "clr"};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "clr_again"};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "set_fb00"};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "set_fb11"};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "clr_fbwrong"};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "set2"};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_set   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_s",       32'(bus.s),       32'd0);
    chk("rst_r",       32'(bus.r),       32'd0);
    chk("rst_ready",   32'(bus.ready),   32'd1);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_err",     32'(bus.err),     32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].set, tbl[i].fen, tbl[i].fq, tbl[i].fqb,
             tbl[i].experr, tbl[i].tag);
    end
    chk("latch_q_after_set2", 32'(bus.q_fb), 32'd1);

    for (int i = 0; i < 300; i++) begin
      run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "sat");
    end
    chk("err_cnt_saturated", 32'(bus.err_cnt), 32'd255);

    // req_valid held high for cycles 0..9.
    bus.req_valid = 1'b1;
    bus.req_set   = 1'b1;
    for (int k = 0; k <= 2 * LAT + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 10) bus.req_valid = 1'b0;
      chk($sformatf("hold_c%0d_ready", k), 32'(bus.ready),
          32'((k == 0) || (k == LAT + 1) || (k == 2 * LAT + 2)));
      chk($sformatf("hold_c%0d_done", k), 32'(bus.done),
          32'((k == LAT) || (k == 2 * LAT + 1)));
    end
    bus.req_valid = 1'b0;
    @(negedge clk);

    // Abort a clear pulse with reset in its second cycle.
    bus.req_valid = 1'b1;
    bus.req_set   = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_r_high", 32'(bus.r), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sr_low",  32'({bus.s, bus.r}), 32'd0);
    chk("abort_ready",   32'(bus.ready),      32'd1);
    chk("abort_err_cnt", 32'(bus.err_cnt),    32'd0);
    exp_cnt = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk($sformatf("abort_c%0d_no_done", k),
          32'({bus.done, bus.err, bus.s, bus.r, bus.ready}), 32'b00001);
    end

    run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_abort_set");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
